// File: rtl/result_drain.sv
// Result drain: walks the systolic array accumulators and streams them out as bytes over valid/ready.
// Optional build macro DRAIN_SAT_EN: send one signed-saturated byte per result instead of two.
module result_drain #(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dump_start,
  input  logic                 store_req,
  input  logic [1:0]           store_row,
  input  logic [1:0]           store_col,
  output logic [1:0]           array_output_row,
  output logic [1:0]           array_output_column,
  input  logic [ACC_WIDTH-1:0] array_result,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SELECT, SEND_LO, SEND_HI} state_t;

  localparam logic [1:0] LAST_IDX = 2'(ARRAY_SIZE - 1);

  state_t               state_reg, state_next;
  logic [1:0]           row_reg, row_next;
  logic [1:0]           col_reg, col_next;
  logic                 dump_mode_reg, dump_mode_next;
  logic [ACC_WIDTH-1:0] hold_reg, hold_next;
  logic                 done_reg, done_next;
  logic [7:0]           lo_byte;
  logic                 elem_done;
  logic                 last_elem;

`ifdef DRAIN_SAT_EN
  // In range exactly when every bit from 7 upward equals the sign bit.
  always_comb begin
    lo_byte = hold_reg[7:0];
    if (!(hold_reg[ACC_WIDTH-1:7] == '0 || hold_reg[ACC_WIDTH-1:7] == '1))
      lo_byte = hold_reg[ACC_WIDTH-1] ? 8'h80 : 8'h7F;
  end
`else
  assign lo_byte = hold_reg[7:0];
`endif

  assign last_elem = !dump_mode_reg || (row_reg == LAST_IDX && col_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      col_reg       <= '0;
      dump_mode_reg <= 1'b0;
      hold_reg      <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      dump_mode_reg <= dump_mode_next;
      hold_reg      <= hold_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    dump_mode_next = dump_mode_reg;
    hold_next      = hold_reg;
    done_next      = 1'b0;
    elem_done      = 1'b0;
    out_valid      = 1'b0;
    out_data       = 8'h00;

    case (state_reg)
      IDLE: begin
        if (dump_start) begin
          row_next       = '0;
          col_next       = '0;
          dump_mode_next = 1'b1;
          state_next     = SELECT;
        end else if (store_req) begin
          row_next       = store_row;
          col_next       = store_col;
          dump_mode_next = 1'b0;
          state_next     = SELECT;
        end
      end
      SELECT: begin
        hold_next  = array_result;
        state_next = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_data  = lo_byte;
        if (out_ready) begin
`ifdef DRAIN_SAT_EN
          elem_done = 1'b1;
`else
          state_next = SEND_HI;
`endif
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_data  = hold_reg[15:8];
        if (out_ready)
          elem_done = 1'b1;
      end
      default: state_next = IDLE;
    endcase

    // Element fully accepted: finish the request or step row-major to the next PE.
    if (elem_done) begin
      if (last_elem) begin
        done_next  = 1'b1;
        state_next = IDLE;
      end else begin
        state_next = SELECT;
        if (col_reg == LAST_IDX) begin
          col_next = '0;
          row_next = row_reg + 2'd1;
        end else begin
          col_next = col_reg + 2'd1;
        end
      end
    end
  end

  assign array_output_row    = row_reg;
  assign array_output_column = col_reg;
  assign busy                = (state_reg != IDLE);
  assign done                = done_reg;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: byte stream, latency, backpressure, collisions and reset
// against a request-level reference model.
module tb_result_drain;
`ifdef DRAIN_SAT_EN
  localparam int BPE = 1;
`else
  localparam int BPE = 2;
`endif
  localparam int ELEM_CYC = BPE + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_start = 1'b0;
  logic        store_req = 1'b0;
  logic [1:0]  store_row = 2'd0;
  logic [1:0]  store_col = 2'd0;
  logic [1:0]  array_output_row;
  logic [1:0]  array_output_column;
  logic [15:0] array_result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  // PE contents: 0 = random table, 1 = r*4+c+0x100, 2 = -(r*4+c)
  logic [1:0]  pattern = 2'd0;
  logic [15:0] pe_mem [16];

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int obs_rd = 0;
  int done_cnt = 0;
  int stall_checks = 0;
  int stall_errs = 0;
  logic stall_pending = 1'b0;
  logic [7:0] stall_data = 8'h00;
  int cycle_cnt = 0;
  int req_cycle = 0;

  result_drain #(.ARRAY_SIZE(4), .ACC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .dump_start(dump_start), .store_req(store_req),
    .store_row(store_row), .store_col(store_col),
    .array_output_row(array_output_row), .array_output_column(array_output_column),
    .array_result(array_result), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [15:0] value_of(input int r, input int c);
    case (pattern)
      2'd1:    return 16'(256 + r * 4 + c);
      2'd2:    return 16'(-(r * 4 + c));
      default: return pe_mem[r * 4 + c];
    endcase
  endfunction

  always_comb array_result = value_of(int'(array_output_row), int'(array_output_column));

  // Expected bytes for one element.
  function automatic void push_elem(input int r, input int c);
    logic [15:0] v;
    int s;
    v = value_of(r, c);
    s = int'($signed(v));
`ifdef DRAIN_SAT_EN
    if (s > 127)       exp_q.push_back(8'h7F);
    else if (s < -128) exp_q.push_back(8'h80);
    else               exp_q.push_back(v[7:0]);
`else
    if (s != 0 || s == 0) begin
      exp_q.push_back(v[7:0]);
      exp_q.push_back(v[15:8]);
    end
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_pending) begin
        stall_checks++;
        if (!out_valid || out_data !== stall_data) stall_errs++;
      end
      stall_pending = out_valid && !out_ready;
      stall_data    = out_data;
      if (out_valid && out_ready) obs_q.push_back(out_data);
      if (done) done_cnt++;
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic send_req(input bit d, input bit s, input logic [1:0] r, input logic [1:0] c);
    @(negedge clk);
    dump_start = d;
    store_req  = s;
    store_row  = r;
    store_col  = c;
    @(posedge clk);
    #1;
    req_cycle  = cycle_cnt;
    dump_start = 1'b0;
    store_req  = 1'b0;
    if (d) begin
      for (int i = 0; i < 16; i++) push_elem(i / 4, i % 4);
    end else if (s) begin
      push_elem(int'(r), int'(c));
    end
  endtask

  task automatic wait_done(input bit rand_rdy);
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      n++;
      if (n > 3000) begin
        check("done_timeout", 32'd0, 32'd1);
        break;
      end
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
  endtask

  task automatic finish_req(input string tag, input int exp_lat, input bit rand_rdy, input int done_base);
    int lat, nobs, nexp;
    wait_done(rand_rdy);
    lat = cycle_cnt - req_cycle;
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, done, 1'b0);
    check({tag, "_done_count"}, done_cnt - done_base, 1);
    nobs = obs_q.size() - obs_rd;
    nexp = exp_q.size();
    check({tag, "_byte_count"}, nobs, nexp);
    for (int i = 0; i < nobs && i < nexp; i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q[obs_rd + i], exp_q[i]);
    $display("%s: %0d bytes, latency %0d, stalls %0d", tag, nobs, lat, stall_checks);
    obs_rd = obs_q.size();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    for (int i = 0; i < 16; i++) pe_mem[i] = 16'($urandom);

    // Reset held with dump_start high
    rst_n = 1'b0;
    dump_start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sel", {array_output_row, array_output_column}, 4'h0);
    rst_n = 1'b1;
    dump_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_bytes", obs_q.size(), 0);
    $display("reset: busy %0d, bytes %0d", busy, obs_q.size());

    // Single store of 0x1234 at (2,1)
    pattern = 2'd0;
    pe_mem[9] = 16'h1234;
    base = done_cnt;
    send_req(1'b0, 1'b1, 2'd2, 2'd1);
    check("store_sel_row", array_output_row, 2'd2);
    check("store_sel_col", array_output_column, 2'd1);
    check("store_busy", busy, 1'b1);
    finish_req("store_2_1", ELEM_CYC, 1'b0, done_cnt);

    // Full dumps, positive and negative patterns
    pattern = 2'd1;
    base = done_cnt;
    send_req(1'b1, 1'b0, 2'd0, 2'd0);
    finish_req("dump_pos", 16 * ELEM_CYC, 1'b0, base);
    pattern = 2'd2;
    base = done_cnt;
    send_req(1'b1, 1'b0, 2'd0, 2'd0);
    finish_req("dump_neg", 16 * ELEM_CYC, 1'b0, base);

    // Backpressure: 5 stalled cycles while a byte of element 2 is offered
    pattern = 2'd1;
    base = done_cnt;
    send_req(1'b1, 1'b0, 2'd0, 2'd0);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if ((obs_q.size() - obs_rd >= 5 && out_valid) || n > 500) break;
    end
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    out_ready = 1'b1;
    finish_req("dump_backpressure", 16 * ELEM_CYC + 5, 1'b0, base);
    check("stall_stable_errs", stall_errs, 0);
    check("stall_cycles_seen", stall_checks, 5);

    // dump_start and store_req together: dump wins
    pattern = 2'd0;
    for (int i = 0; i < 16; i++) pe_mem[i] = 16'($urandom);
    base = done_cnt;
    send_req(1'b1, 1'b1, 2'd3, 2'd2);
    finish_req("dump_collide", 16 * ELEM_CYC, 1'b0, base);

    // store_req mid-dump is ignored
    base = done_cnt;
    send_req(1'b1, 1'b0, 2'd0, 2'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    store_req = 1'b1;
    store_row = 2'd1;
    store_col = 2'd1;
    @(posedge clk);
    #1;
    store_req = 1'b0;
    finish_req("dump_store_mid", 16 * ELEM_CYC, 1'b0, base);

    // Reset during element (1,3), then a store of (0,0)
    pattern = 2'd1;
    base = done_cnt;
    send_req(1'b1, 1'b0, 2'd0, 2'd0);
    n = 0;
    forever begin
      @(posedge clk);
      #2;
      n++;
      if ((obs_q.size() - obs_rd >= 7 * BPE && out_valid) || n > 500) break;
    end
    check("mid_rst_sel", {array_output_row, array_output_column}, 4'h7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - base, 0);
    $display("reset mid-dump: %0d bytes before reset", obs_q.size() - obs_rd);
    obs_rd = obs_q.size();
    exp_q.delete();
    send_req(1'b0, 1'b1, 2'd0, 2'd0);
    finish_req("store_after_rst", ELEM_CYC, 1'b0, done_cnt);

    // Randomized requests with random consumer backpressure
    pattern = 2'd0;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) pe_mem[i] = 16'($urandom);
      base = done_cnt;
      if ($urandom_range(0, 3) == 0)
        send_req(1'b1, 1'b0, 2'd0, 2'd0);
      else
        send_req(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      finish_req($sformatf("rand%0d", t), -1, 1'b1, base);
    end
    check("final_stall_errs", stall_errs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Result drain engine for the Mini TPU: the read side of the systolic array, complementing the instruction control unit that fills the operand memories and starts the array. On a full-dump or single-element request it walks the 4x4 array's accumulators through the array output row/column select, captures each result, and streams it out as bytes over a valid/ready handshake toward the chip's output pins. It sits between the systolic array result mux and the top-level output port.

## Interface
Parameters:
- ARRAY_SIZE, 4, rows and columns of the array; row/column selects are 2 bits wide.
- ACC_WIDTH, 16, width of one accumulator result; must be 16.

Ports. One clock; reset is synchronous and active-low.
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- dump_start  input  1  one-cycle request: stream all 16 results.
- store_req  input  1  one-cycle request: stream one result.
- store_row  input  2  row for store_req.
- store_col  input  2  column for store_req.
- array_output_row  output  2  row select to the array result mux.
- array_output_column  output  2  column select to the array result mux.
- array_result  input  ACC_WIDTH  combinational result of the selected PE, signed two's complement.
- out_data  output  8  outgoing byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer accepts the byte this cycle.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last byte of a request is accepted.

## Operation
- States: IDLE, SELECT, SEND_LO, SEND_HI.
- IDLE: dump_start loads row=0, col=0, mode=DUMP, goes to SELECT. Otherwise store_req loads store_row/store_col, mode=SINGLE, goes to SELECT. Both high on the same cycle: dump_start wins and store_req is dropped.
- SELECT: drives array_output_row/array_output_column with the current address. On the next edge it captures array_result into a 16-bit holding register and goes to SEND_LO.
- SEND_LO: out_valid=1, out_data=hold[7:0]. On out_valid&&out_ready, goes to SEND_HI.
- SEND_HI: out_valid=1, out_data=hold[15:8]. On handshake:
  - If mode=SINGLE, or mode=DUMP at address (3,3): pulse done and go to IDLE.
  - Otherwise advance the address in row-major order (col+1; col wrap 3->0 increments row) and go to SELECT.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0. out_ready has no effect when out_valid=0.
- dump_start and store_req are ignored while busy=1. They are not queued.
- The select outputs hold their last value outside SELECT. The array mux is combinational, so holding is harmless.
- Reset values: state IDLE, array_output_row=0, array_output_column=0, out_data=0, out_valid=0, busy=0, done=0, holding register 0.
- Reset asserted mid-transfer returns to IDLE on that edge. The partial element is discarded, no done pulse is issued, and out_valid drops immediately.

## Timing
- Request sampled at edge k: SELECT during cycle k..k+1, result captured at edge k+1, first byte valid from edge k+1.
- With out_ready tied high, each element costs 3 cycles (SELECT, SEND_LO, SEND_HI):
  - full dump: 48 cycles from request edge to the done edge;
  - single element: 3 cycles.
- done is high for exactly the cycle after the final handshake edge. busy is low in that same cycle, and a new request is accepted in that cycle.
- array_result must be settled within one cycle of the select change. It is sampled only at the end of SELECT.

## Configuration
- DRAIN_SAT_EN defined:
  - each result is saturated to signed 8 bits before transmission: values > 127 send 0x7F, values < -128 send 0x80, otherwise the low byte is sent;
  - SEND_HI is skipped, so SEND_LO transitions directly to the end-of-element logic;
  - cost is 2 cycles per element, 32 cycles for a full dump.
- DRAIN_SAT_EN undefined: full 16-bit results, two bytes per element, low byte first, as described above.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with dump_start=1 -> all outputs 0, busy=0, no bytes emitted. After release, busy=0 until a new request.
- Single store: array_result=0x1234 when (2,1) selected, store_req with row=2, col=1, out_ready=1 ->
  - select outputs 2/1 in SELECT;
  - bytes 0x34 then 0x12;
  - done 3 cycles after the request. With DRAIN_SAT_EN: one byte 0x7F.
- Full dump: PE(r,c) returns r*4+c+0x0100, out_ready=1 -> 32 bytes 0x00,0x01,0x01,0x01,...,0x0F,0x01 in row-major order; done at cycle 48. With DRAIN_SAT_EN: 16 bytes of 0x7F at cycle 32. With PE(r,c) = -(r*4+c) instead: 16 bytes 0x00,0xFF..0xF1.
- Backpressure: out_ready low for 5 cycles during SEND_HI of element (0,2) -> out_data and out_valid stable throughout, no skipped or duplicated byte, done delayed by exactly 5 cycles.
- Collisions: dump_start and store_req together -> full dump runs and the store is dropped. store_req mid-dump -> ignored, byte count still 32.
- Reset mid-dump: rst_n=0 for one edge during element (1,3) -> out_valid=0 and IDLE on that edge, no done pulse. A following store_req for (0,0) completes normally.
